spi_wb_bridge: RTL and testbench

//  SPI slave (mode 0, MSB first) that acts as a Wishbone bus master, so an external host can load and inspect memory.
//  It is the counterpart of the on-chip SPI master. It attaches to a free conbus master port (m2).
//  The host reads and writes 32-bit words anywhere in the SoC map, e.g. to load bram0 at 0x00000000.
//  All logic runs on clk. SCLK, SS_N and MOSI are synchronised (2-FF) and edge-detected; no SCLK clock domain.

---
 rtl/spi_wb_bridge.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_spi_wb_bridge.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_wb_bridge.sv
`default_nettype none
// ============================================================================
// Module      : spi_wb_bridge
// Description : SPI slave (mode 0, MSB first) acting as a Wishbone master.
//               An external host issues WRITE / READ / NOP frames to access
//               32-bit words anywhere in the SoC map. All SPI pins are
//               synchronised into clk; there is no SCLK clock domain.
//               Optional feature macro: SPI_WB_AUTOINC_EN (address
//               auto-increment and frame continuation after each word).
// Revision    : 1.0 - initial release
// ============================================================================
module spi_wb_bridge #(
  parameter int TIMEOUT = 32,
  parameter int TO_W    = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_sclk,
  input  logic        spi_ss_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        miso_oe,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  output logic        busy,
  output logic        err
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_CMD   = 4'd1,
    S_ADDR  = 4'd2,
    S_WDATA = 4'd3,
    S_WB_WR = 4'd4,
    S_WB_RD = 4'd5,
    S_TURN  = 4'd6,
    S_RDATA = 4'd7,
    S_DONE  = 4'd8,
    S_DROP  = 4'd9
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;

  logic [2:0]  r_sclk_s;
  logic [2:0]  r_ss_s;
  logic [1:0]  r_mosi_s;
  logic [2:0]  r_bit_cnt;
  logic [1:0]  r_byte_cnt;
  logic [30:0] r_sr_in;
  logic [31:0] r_sr_out;
  logic        r_miso;
  logic [31:0] r_adr;
  logic [31:0] r_wdat;
  logic [31:0] r_rdata;
  logic        r_cyc;
  logic        r_we;
  logic        r_err;
  logic        r_rd;
  logic        r_first;
  logic        r_abort;
  logic [TO_W-1:0] r_to_cnt;

  logic        w_sclk_rise, w_sclk_fall, w_ss_low, w_ss_fall, w_ss_rise;
  logic        w_rise_act, w_fall_act, w_byte_done;
  logic [31:0] w_word_in;
  logic [7:0]  w_byte_in;
  logic        w_timeout, w_cyc_end;
  logic        w_load_adr, w_load_wdat, w_start_cyc, w_inc_adr, w_load_out, w_clr_err;

  // Edge detection on the synchronised SPI pins
  assign w_sclk_rise = r_sclk_s[1] & ~r_sclk_s[2];
  assign w_sclk_fall = ~r_sclk_s[1] & r_sclk_s[2];
  assign w_ss_low    = ~r_ss_s[1];
  assign w_ss_fall   = ~r_ss_s[1] & r_ss_s[2];
  assign w_ss_rise   = r_ss_s[1] & ~r_ss_s[2];
  assign w_rise_act  = w_sclk_rise & w_ss_low & (r_state != S_IDLE);
  assign w_fall_act  = w_sclk_fall & w_ss_low;
  assign w_byte_done = w_rise_act & (r_bit_cnt == 3'd7);
  assign w_word_in   = {r_sr_in, r_mosi_s[1]};
  assign w_byte_in   = w_word_in[7:0];

  // A cycle ends on ack, or after TIMEOUT clocks without one
  assign w_timeout = r_cyc & ~wb_ack_i & (r_to_cnt == TO_W'(TIMEOUT - 1));
  assign w_cyc_end = r_cyc & (wb_ack_i | w_timeout);

  assign spi_miso = r_miso;
  assign miso_oe  = w_ss_low;
  assign wb_adr_o = r_adr;
  assign wb_dat_o = r_wdat;
  assign wb_sel_o = 4'hF;
  assign wb_we_o  = r_we;
  assign wb_cyc_o = r_cyc;
  assign wb_stb_o = r_cyc;
  assign busy     = (r_state != S_IDLE);
  assign err      = r_err;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nx;
  end

  // Next-state decode and datapath control strobes
  always_comb begin
    w_state_nx  = r_state;
    w_load_adr  = 1'b0;
    w_load_wdat = 1'b0;
    w_start_cyc = 1'b0;
    w_inc_adr   = 1'b0;
    w_load_out  = 1'b0;
    w_clr_err   = 1'b0;
    case (r_state)
      S_IDLE: if (w_ss_fall) w_state_nx = S_CMD;
      S_CMD: begin
        if (w_ss_rise) w_state_nx = S_IDLE;
        else if (w_byte_done) begin
          case (w_byte_in)
            8'h01, 8'h02: w_state_nx = S_ADDR;
            8'h00: begin
              w_clr_err  = 1'b1;
              w_state_nx = S_DONE;
            end
            default: w_state_nx = S_DROP;
          endcase
        end
      end
      S_ADDR: begin
        if (w_ss_rise) w_state_nx = S_IDLE;
        else if (w_byte_done && r_byte_cnt == 2'd0) begin
          w_load_adr = 1'b1;
          if (r_rd) begin
            w_start_cyc = 1'b1;
            w_state_nx  = S_WB_RD;
          end else begin
            w_state_nx  = S_WDATA;
          end
        end
      end
      S_WDATA: begin
        if (w_ss_rise) w_state_nx = S_IDLE;
        else if (w_byte_done && r_byte_cnt == 2'd0) begin
          w_load_wdat = 1'b1;
          w_start_cyc = 1'b1;
          w_state_nx  = S_WB_WR;
        end
      end
      S_WB_WR, S_WB_RD: begin
        // A cycle in flight always finishes; an ended frame then skips ahead
        if (w_cyc_end) begin
          if (r_abort || !w_ss_low) w_state_nx = w_ss_low ? S_DROP : S_IDLE;
          else if (r_state == S_WB_RD) w_state_nx = r_first ? S_TURN : S_RDATA;
          else begin
`ifdef SPI_WB_AUTOINC_EN
            w_inc_adr  = 1'b1;
            w_state_nx = S_WDATA;
`else
            w_state_nx = S_DONE;
`endif
          end
        end
      end
      S_TURN: begin
        if (w_ss_rise) w_state_nx = S_IDLE;
        else if (w_byte_done && r_byte_cnt == 2'd1) begin
          w_load_out = 1'b1;
`ifdef SPI_WB_AUTOINC_EN
          w_inc_adr   = 1'b1;
          w_start_cyc = 1'b1;
          w_state_nx  = S_WB_RD;
`else
          w_state_nx  = S_RDATA;
`endif
        end
      end
      S_RDATA: begin
        if (w_ss_rise) w_state_nx = S_IDLE;
        else if (w_byte_done && r_byte_cnt == 2'd1) begin
`ifdef SPI_WB_AUTOINC_EN
          w_load_out  = 1'b1;
          w_inc_adr   = 1'b1;
          w_start_cyc = 1'b1;
          w_state_nx  = S_WB_RD;
`else
          w_state_nx  = S_DONE;
`endif
        end
      end
      S_DONE, S_DROP: if (w_ss_rise) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Two-flop synchronisers plus one history stage for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sclk_s <= 3'b000;
      r_ss_s   <= 3'b111;
      r_mosi_s <= 2'b00;
    end else begin
      r_sclk_s <= {r_sclk_s[1:0], spi_sclk};
      r_ss_s   <= {r_ss_s[1:0], spi_ss_n};
      r_mosi_s <= {r_mosi_s[0], spi_mosi};
    end
  end

  // Receive side: bit/byte counters and MOSI shift register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bit_cnt  <= 3'd0;
      r_byte_cnt <= 2'd0;
      r_sr_in    <= '0;
      r_rd       <= 1'b0;
    end else begin
      if (w_ss_fall) begin
        r_bit_cnt  <= 3'd0;
        r_byte_cnt <= 2'd0;
      end else if (w_rise_act) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
        r_sr_in   <= w_word_in[30:0];
        if (r_bit_cnt == 3'd7) r_byte_cnt <= r_byte_cnt + 2'd1;
      end
      if (r_state == S_CMD && w_byte_done) r_rd <= (w_byte_in == 8'h02);
    end
  end

  // Transmit side: status byte at frame start, read data, zero otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_miso   <= 1'b0;
      r_sr_out <= '0;
    end else if (w_ss_fall) begin
      if (r_state == S_IDLE) begin
        r_miso   <= 1'b1;
        r_sr_out <= {6'b010000, r_err, 25'd0};
      end else begin
        r_miso   <= 1'b0;
        r_sr_out <= '0;
      end
    end else if (w_ss_rise) begin
      r_miso   <= 1'b0;
      r_sr_out <= '0;
    end else if (w_load_out) begin
      r_sr_out <= r_rdata;
    end else if (w_fall_act) begin
      r_miso   <= r_sr_out[31];
      r_sr_out <= {r_sr_out[30:0], 1'b0};
    end
  end

  // Wishbone master: address/data registers, cycle control, timeout, error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_adr    <= '0;
      r_wdat   <= '0;
      r_rdata  <= '0;
      r_cyc    <= 1'b0;
      r_we     <= 1'b0;
      r_err    <= 1'b0;
      r_first  <= 1'b0;
      r_abort  <= 1'b0;
      r_to_cnt <= '0;
    end else begin
      if (w_load_adr)     r_adr <= w_word_in;
      else if (w_inc_adr) r_adr <= r_adr + 32'd4;
      if (w_load_wdat) r_wdat <= w_word_in;
      if (w_load_adr)      r_first <= 1'b1;
      else if (w_load_out) r_first <= 1'b0;
      if (w_start_cyc) begin
        r_cyc <= 1'b1;
        r_we  <= ~r_rd;
      end else if (w_cyc_end) begin
        r_cyc <= 1'b0;
        r_we  <= 1'b0;
      end
      if (w_cyc_end && !r_we) r_rdata <= wb_ack_i ? wb_dat_i : 32'hFFFF_FFFF;
      if (!r_cyc || w_cyc_end) r_to_cnt <= '0;
      else                     r_to_cnt <= r_to_cnt + 1'b1;
      // Frame ended under a live cycle: remember it so the cycle ends in IDLE/DROP
      if (w_cyc_end)              r_abort <= 1'b0;
      else if (r_cyc && w_ss_rise) r_abort <= 1'b1;
      if (w_timeout)      r_err <= 1'b1;
      else if (w_clr_err) r_err <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_wb_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_wb_bridge
// Description : Directed, table-driven bench for spi_wb_bridge with an SPI
//               host model and a Wishbone slave/memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_spi_wb_bridge;

  localparam int HALF    = 80;
  localparam int ACK_DLY = 2;
`ifdef SPI_WB_AUTOINC_EN
  localparam int RD_CYC  = 2;
  localparam int AI_WR   = 3;
`else
  localparam int RD_CYC  = 1;
  localparam int AI_WR   = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_sclk, spi_ss_n, spi_mosi, spi_miso, miso_oe;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, busy, err;

  spi_wb_bridge #(.TIMEOUT(32), .TO_W(6)) dut (
    .clk(clk), .rst(rst),
    .spi_sclk(spi_sclk), .spi_ss_n(spi_ss_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .miso_oe(miso_oe),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    logic [3:0]  sel;
  } wb_rec_t;

  typedef struct {
    logic        rd;
    logic [31:0] adr;
    logic [31:0] dat;
  } vec_t;

  wb_rec_t     wb_log[$];
  logic [31:0] mem [logic [31:0]];
  int          ack_wait;
  int          cyc_starts = 0;
  int          cur_len = 0;
  int          last_len = 0;
  logic        prev_cyc = 1'b0;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  txb [0:15];
  logic [7:0]  rxb [0:15];

  // Wishbone slave with fixed ack latency; region 0x7xxxxxxx never acks
  always @(posedge clk) begin
    if (!rst) begin
      wb_ack_i <= 1'b0;
      wb_dat_i <= 32'h0;
      ack_wait = 0;
      mem[32'h4000_0000] = 32'h1234_5678;
    end else begin
      wb_ack_i <= 1'b0;
      if (!wb_cyc_o) ack_wait = 0;
      if (wb_cyc_o && wb_stb_o && !wb_ack_i && wb_adr_o[31:28] != 4'h7) begin
        if (ack_wait == ACK_DLY) begin
          ack_wait = 0;
          wb_ack_i <= 1'b1;
          if (wb_we_o) mem[wb_adr_o] = wb_dat_o;
          else         wb_dat_i <= mem.exists(wb_adr_o) ? mem[wb_adr_o] : 32'h0;
        end else begin
          ack_wait++;
        end
      end
      if (wb_cyc_o && wb_stb_o && wb_ack_i)
        wb_log.push_back('{wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o});
      if (wb_cyc_o) begin
        if (!prev_cyc) begin
          cyc_starts++;
          cur_len = 1;
        end else begin
          cur_len++;
        end
      end else if (prev_cyc) begin
        last_len = cur_len;
      end
      prev_cyc = wb_cyc_o;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = tx[i];
      #(HALF);
      spi_sclk = 1'b1;
      rx[i]    = spi_miso;
      #(HALF);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic spi_bytes(input int first, input int n);
    for (int b = first; b < first + n; b++) spi_byte(txb[b], rxb[b]);
  endtask

  task automatic spi_frame(input int n);
    spi_ss_n = 1'b0;
    #(HALF);
    spi_bytes(0, n);
    #(HALF);
    spi_ss_n = 1'b1;
    #(400);
  endtask

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 200; k++) begin
      @(posedge clk);
      if (!busy) break;
    end
    #1;
    check(name, {31'd0, busy}, 32'd0);
    @(negedge clk);
  endtask

  task automatic load_cmd(input logic [7:0] cmd, input logic [31:0] adr, input logic [31:0] dat);
    txb[0] = cmd;
    txb[1] = adr[31:24]; txb[2] = adr[23:16]; txb[3] = adr[15:8]; txb[4] = adr[7:0];
    txb[5] = dat[31:24]; txb[6] = dat[23:16]; txb[7] = dat[15:8]; txb[8] = dat[7:0];
    for (int b = 9; b < 16; b++) txb[b] = 8'h00;
  endtask

  function automatic logic [7:0] or_rx(input int first, input int last);
    logic [7:0] v = 8'h00;
    for (int b = first; b <= last; b++) v = v | rxb[b];
    return v;
  endfunction

  // Global bound on run time
  initial begin
    #3ms;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs [0:6];
    int   s0, l0;
    logic [31:0] rdw;

    vecs[0] = '{1'b1, 32'h4000_0000, 32'h1234_5678};
    vecs[1] = '{1'b0, 32'h0000_0000, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 32'h0000_0000, 32'hDEAD_BEEF};
    vecs[3] = '{1'b0, 32'h0000_0010, 32'hA5A5_0F0F};
    vecs[4] = '{1'b1, 32'h0000_0010, 32'hA5A5_0F0F};
    vecs[5] = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0001};
    vecs[6] = '{1'b1, 32'hFFFF_FFFC, 32'h0000_0001};

    rst = 1'b0; spi_sclk = 1'b0; spi_ss_n = 1'b1; spi_mosi = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_miso", {31'd0, spi_miso}, 32'd0);
    check("rst_oe",   {31'd0, miso_oe},  32'd0);
    check("rst_cyc",  {31'd0, wb_cyc_o}, 32'd0);
    check("rst_stb",  {31'd0, wb_stb_o}, 32'd0);
    check("rst_we",   {31'd0, wb_we_o},  32'd0);
    check("rst_adr",  wb_adr_o, 32'd0);
    check("rst_dat",  wb_dat_o, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err",  {31'd0, err},  32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Table: single-word writes and reads
    for (int i = 0; i < 7; i++) begin
      s0 = cyc_starts;
      l0 = wb_log.size();
      load_cmd(vecs[i].rd ? 8'h02 : 8'h01, vecs[i].adr, vecs[i].rd ? 32'h0 : vecs[i].dat);
      spi_frame(vecs[i].rd ? 10 : 9);
      wait_idle("tbl_idle");
      check("tbl_status", {24'd0, rxb[0]}, 32'h0000_00A0);
      check("tbl_cycles", cyc_starts - s0, vecs[i].rd ? RD_CYC : 1);
      if (wb_log.size() > l0) begin
        check("tbl_adr", wb_log[l0].adr, vecs[i].adr);
        check("tbl_we",  {31'd0, wb_log[l0].we}, {31'd0, ~vecs[i].rd});
        check("tbl_sel", {28'd0, wb_log[l0].sel}, 32'hF);
        if (vecs[i].rd) begin
          rdw = {rxb[6], rxb[7], rxb[8], rxb[9]};
          check("tbl_rdata", rdw, vecs[i].dat);
          check("tbl_turn_miso", {24'd0, or_rx(1, 5)}, 32'd0);
        end else begin
          check("tbl_wdat", wb_log[l0].dat, vecs[i].dat);
          check("tbl_wr_miso", {24'd0, or_rx(1, 8)}, 32'd0);
        end
      end else begin
        check("tbl_ack_seen", wb_log.size() - l0, 1);
      end
    end

    // Timeout: slave never acks, data reads back all ones, err sets
    s0 = cyc_starts;
    l0 = wb_log.size();
    load_cmd(8'h02, 32'h7000_0000, 32'h0);
    spi_frame(10);
    wait_idle("to_idle");
    rdw = {rxb[6], rxb[7], rxb[8], rxb[9]};
    check("to_rdata", rdw, 32'hFFFF_FFFF);
    check("to_len", last_len, 32);
    check("to_cycles", cyc_starts - s0, RD_CYC);
    check("to_acks", wb_log.size() - l0, 0);
    check("to_err", {31'd0, err}, 32'd1);

    // NOP shows the sticky error, then clears it
    load_cmd(8'h00, 32'h0, 32'h0);
    spi_frame(2);
    wait_idle("nop1_idle");
    check("nop1_status", {24'd0, rxb[0]}, 32'h0000_00A1);
    check("nop1_err", {31'd0, err}, 32'd0);
    spi_frame(2);
    wait_idle("nop2_idle");
    check("nop2_status", {24'd0, rxb[0]}, 32'h0000_00A0);

    // Abort after two address bytes: no cycle, busy drops quickly
    s0 = cyc_starts;
    load_cmd(8'h01, 32'h1111_2222, 32'h0);
    spi_ss_n = 1'b0;
    #(HALF);
    check("abort_oe", {31'd0, miso_oe}, 32'd1);
    spi_bytes(0, 3);
    #(HALF);
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    spi_ss_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    #(400);
    check("abort_cycles", cyc_starts - s0, 0);
    l0 = wb_log.size();
    load_cmd(8'h01, 32'h0000_0020, 32'hCAFE_F00D);
    spi_frame(9);
    wait_idle("post_abort_idle");
    check("post_abort_acks", wb_log.size() - l0, 1);
    if (wb_log.size() > l0) begin
      check("post_abort_adr", wb_log[l0].adr, 32'h0000_0020);
      check("post_abort_dat", wb_log[l0].dat, 32'hCAFE_F00D);
    end

    // Unknown command: dropped, MISO silent after the status byte
    s0 = cyc_starts;
    for (int b = 0; b < 16; b++) txb[b] = 8'hFF;
    txb[0] = 8'h7F;
    spi_frame(9);
    wait_idle("bad_idle");
    check("bad_status", {24'd0, rxb[0]}, 32'h0000_00A0);
    check("bad_miso", {24'd0, or_rx(1, 8)}, 32'd0);
    check("bad_cycles", cyc_starts - s0, 0);

    // New frame while a cycle is in flight is dropped entirely
    s0 = cyc_starts;
    l0 = wb_log.size();
    load_cmd(8'h02, 32'h7000_0000, 32'h0);
    spi_ss_n = 1'b0;
    #(HALF);
    spi_bytes(0, 5);
    #(HALF);
    spi_ss_n = 1'b1;
    #(40);
    check("drop_inflight", {31'd0, wb_cyc_o}, 32'd1);
    spi_ss_n = 1'b0;
    load_cmd(8'h01, 32'h0000_0030, 32'h1234_5678);
    #(HALF);
    spi_bytes(0, 9);
    #(HALF);
    spi_ss_n = 1'b1;
    #(400);
    wait_idle("drop_idle");
    check("drop_cycles", cyc_starts - s0, 1);
    check("drop_acks", wb_log.size() - l0, 0);
    check("drop_err", {31'd0, err}, 32'd1);
    load_cmd(8'h00, 32'h0, 32'h0);
    spi_frame(1);
    wait_idle("drop_nop_idle");
    check("drop_nop_status", {24'd0, rxb[0]}, 32'h0000_00A1);

    // Multi-word write: auto-increment builds write every word
    l0 = wb_log.size();
    load_cmd(8'h01, 32'h0000_0100, 32'h1111_1111);
    txb[9] = 8'h22; txb[10] = 8'h22; txb[11] = 8'h22; txb[12] = 8'h22;
    txb[13] = 8'h33; txb[14] = 8'h33; txb[15] = 8'h33;
    spi_ss_n = 1'b0;
    #(HALF);
    spi_bytes(0, 16);
    spi_byte(8'h33, rxb[15]);
    #(HALF);
    spi_ss_n = 1'b1;
    #(400);
    wait_idle("ai_idle");
    check("ai_count", wb_log.size() - l0, AI_WR);
    for (int k = 0; k < AI_WR; k++) begin
      if (wb_log.size() > l0 + k) begin
        check("ai_adr", wb_log[l0 + k].adr, 32'h100 + 32'(4 * k));
        check("ai_dat", wb_log[l0 + k].dat, {4{8'h11 * 8'(k + 1)}});
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
